rotator_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 8-bit rotate-right unit among up to four requesters. Each requester presents a byte and a 3-bit rotate amount with a valid/ready handshake. The block grants one requester per cycle, rotates its byte right by the requested amount, and holds the result in an output register tagged with the requester ID. It sits between several producer blocks and a single downstream consumer, so a single rotator serves them all at one result per cycle.

---
 rtl/rotator_arbiter.sv | 98 +++++++++
 tb/tb_rotator_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/rotator_arbiter.sv
// rotator_arbiter: round-robin arbiter sharing one 8-bit rotate-right unit
// among up to four requesters, with a registered, ID-tagged result.
module rotator_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [3*NUM_REQ-1:0] req_shift,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 out_valid,
  output logic [7:0]           out_data,
  output logic [1:0]           out_id,
  input  logic                 out_ready
);

  logic       out_valid_q, out_valid_d;
  logic [7:0] out_data_q,  out_data_d;
  logic [1:0] out_id_q,    out_id_d;
  logic [1:0] last_id_q,   last_id_d;

  logic        can_accept;
  logic        found;
  int unsigned winner;
  logic [7:0]  sel_data;
  logic [2:0]  sel_shift;
  logic        xfer;

  // Rotate right by k: the low byte of {a,a} >> k wraps the shifted-out bits.
  function automatic logic [7:0] rotr(input logic [7:0] a, input logic [2:0] k);
    logic [15:0] dbl;
    dbl = {a, a} >> k;
    return dbl[7:0];
  endfunction

  assign can_accept = !out_valid_q || out_ready;

  // Round-robin scan from last_id+1, then operand select and handshake.
  always_comb begin
    found     = 1'b0;
    winner    = 0;
    sel_data  = '0;
    sel_shift = '0;
    req_ready = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      if (!found && req_valid[(32'(last_id_q) + off) % NUM_REQ]) begin
        found  = 1'b1;
        winner = (32'(last_id_q) + off) % NUM_REQ;
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (found && i == winner) begin
        sel_data     = req_data[8*i +: 8];
        sel_shift    = req_shift[3*i +: 3];
        req_ready[i] = can_accept && !reset;
      end
    end
  end

  assign xfer = found && can_accept && !reset;

  // Next-state for the output register and priority pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    last_id_d   = last_id_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = rotr(sel_data, sel_shift);
      out_id_d    = 2'(winner);
      last_id_d   = 2'(winner);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State register with synchronous reset; pointer resets so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      last_id_q   <= 2'(NUM_REQ - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      last_id_q   <= last_id_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_rotator_arbiter.sv
// Self-checking bench for rotator_arbiter: spec-level model compared every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_rotator_arbiter;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [8*N-1:0] req_data;
  logic [3*N-1:0] req_shift;
  logic [N-1:0]  req_ready;
  logic          out_valid;
  logic [7:0]    out_data;
  logic [1:0]    out_id;
  logic          out_ready;

  int tests = 0;
  int fails = 0;

  // model state
  int mv = 0, md = 0, mid = 0, mptr = N - 1;

  rotator_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_shift(req_shift), .req_ready(req_ready), .out_valid(out_valid),
    .out_data(out_data), .out_id(out_id), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rot(input int a, input int k);
    return ((a >> k) | (a << (8 - k))) & 255;
  endfunction

  // first valid requester scanning from mptr+1 with wrap; -1 if none
  function automatic int pick();
    for (int off = 1; off <= N; off++)
      if (req_valid[(mptr + off) % N]) return (mptr + off) % N;
    return -1;
  endfunction

  function automatic int exp_ready();
    int w;
    w = pick();
    if (reset || w < 0 || !(mv == 0 || out_ready)) return 0;
    return 1 << w;
  endfunction

  // model update on the active edge
  always @(posedge clk) begin
    int w;
    if (reset) begin
      mv = 0; md = 0; mid = 0; mptr = N - 1;
    end else begin
      w = pick();
      if (w >= 0 && (mv == 0 || out_ready)) begin
        md   = rot(int'(req_data[8*w +: 8]), int'(req_shift[3*w +: 3]));
        mid  = w;
        mv   = 1;
        mptr = w;
      end else if (mv != 0 && out_ready) begin
        mv = 0;
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    chk("m_ready", int'(req_ready), exp_ready());
    chk("m_valid", int'(out_valid), mv);
    chk("m_data",  int'(out_data),  md);
    chk("m_id",    int'(out_id),    mid);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] d, input logic [2:0] s);
    req_data[8*i +: 8]  = d;
    req_shift[3*i +: 3] = s;
  endtask

  logic [1:0] rr_id   [6];
  logic [7:0] rr_data [6];

  initial begin
    rr_id   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rr_data = '{8'h80, 8'h01, 8'h02, 8'h04, 8'h80, 8'h01};

    // reset held 2 cycles with all requesting
    reset = 1'b1; req_valid = '1; req_data = '0; req_shift = '0; out_ready = 1'b1;
    @(negedge clk);
    chk("rst_ready0", int'(req_ready), 0);
    @(negedge clk);
    chk("rst_ready1", int'(req_ready), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_id", int'(out_id), 0);
    step(); reset = 1'b0;
    @(negedge clk);
    chk("first_grant", int'(req_ready), 4'b0001);
    step(); req_valid = '0;
    step();

    // single requester 2: B4 rotated by 3, 7, 0
    set_req(2, 8'hB4, 3'd3); req_valid = 4'b0100;
    step(); set_req(2, 8'hB4, 3'd7);
    @(negedge clk);
    chk("single_96", int'(out_data), 8'h96);
    chk("single_id", int'(out_id), 2);
    step(); set_req(2, 8'hB4, 3'd0);
    @(negedge clk);
    chk("single_69", int'(out_data), 8'h69);
    chk("single_v", int'(out_valid), 1);
    step(); req_valid = '0;
    @(negedge clk);
    chk("single_B4", int'(out_data), 8'hB4);
    chk("single_v2", int'(out_valid), 1);

    // round robin from a fresh reset
    step(); reset = 1'b1;
    step(); reset = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 8'(8'h01 << i), 3'd1);
    req_valid = '1;
    for (int i = 0; i < 6; i++) begin
      step();
      @(negedge clk);
      chk("rr_id", int'(out_id), int'(rr_id[i]));
      chk("rr_data", int'(out_data), int'(rr_data[i]));
    end

    // backpressure: grant to req 2 lands at this edge, then stall 3 cycles
    step(); out_ready = 1'b0; req_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ready", int'(req_ready), 0);
      chk("bp_id", int'(out_id), 2);
      chk("bp_data", int'(out_data), 8'h02);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_regrant", int'(req_ready), 4'b1000);
    step(); req_valid = '0;
    @(negedge clk);
    chk("bp_id3", int'(out_id), 3);
    chk("bp_data3", int'(out_data), 8'h04);
    step();
    @(negedge clk);
    chk("drain_v", int'(out_valid), 0);

    // sparse: req 3 once, idle, then req 0
    step(); set_req(3, 8'hC3, 3'd4); req_valid = 4'b1000;
    step(); req_valid = '0;
    @(negedge clk);
    chk("sp3_v", int'(out_valid), 1);
    chk("sp3_id", int'(out_id), 3);
    chk("sp3_data", int'(out_data), 8'h3C);
    step();
    @(negedge clk);
    chk("sp_idle_v", int'(out_valid), 0);
    step(); set_req(0, 8'h81, 3'd2); req_valid = 4'b0001;
    step(); req_valid = '0;
    @(negedge clk);
    chk("sp0_id", int'(out_id), 0);
    chk("sp0_data", int'(out_data), 8'h60);
    step();
    @(negedge clk);
    chk("sp_hold_v", int'(out_valid), 0);
    chk("sp_hold_d", int'(out_data), 8'h60);

    // reset mid-stream with a stalled result
    step(); set_req(1, 8'h5A, 3'd0); req_valid = 4'b0010;
    step(); out_ready = 1'b0; req_valid = '0;
    @(negedge clk);
    chk("mid_v", int'(out_valid), 1);
    chk("mid_id", int'(out_id), 1);
    step(); reset = 1'b1; req_valid = '1;
    @(negedge clk);
    chk("mid_rst_ready", int'(req_ready), 0);
    step(); reset = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("mid_v0", int'(out_valid), 0);
    chk("mid_restart", int'(req_ready), 4'b0001);
    step(); req_valid = '0;
    @(negedge clk);
    chk("mid_id0", int'(out_id), 0);
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
